// File: rtl/seg7_scan_if.sv
// Scan-bus bundle between a multiplexed 7-segment driver (master) and the
// receive-side decoder (slave), including the decoder's reconstructed outputs.
interface seg7_scan_if;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic [15:0] value;
    logic        frame_valid;
    logic        err;
    logic [1:0]  err_code;
    logic [3:0]  digit_seen;

    modport master (
        output a_to_g, an,
        input  value, frame_valid, err, err_code, digit_seen
    );

    modport slave (
        input  a_to_g, an,
        output value, frame_valid, err, err_code, digit_seen
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 4-digit seven-segment scan bus, debounces each digit
// window, decodes segments back to hex and publishes complete 16-bit frames.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       clr_n,
    seg7_scan_if.slave scan_io
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_HIT  = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [1:0] ERR_ONEHOT  = 2'b01;
    localparam logic [1:0] ERR_SEG     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Returns {legal, nibble}; unknown patterns come back with legal=0.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h7E:   decode_seg = {1'b1, 4'h0};
            7'h30:   decode_seg = {1'b1, 4'h1};
            7'h6D:   decode_seg = {1'b1, 4'h2};
            7'h79:   decode_seg = {1'b1, 4'h3};
            7'h33:   decode_seg = {1'b1, 4'h4};
            7'h5B:   decode_seg = {1'b1, 4'h5};
            7'h5F:   decode_seg = {1'b1, 4'h6};
            7'h70:   decode_seg = {1'b1, 4'h7};
            7'h7F:   decode_seg = {1'b1, 4'h8};
            7'h7B:   decode_seg = {1'b1, 4'h9};
            7'h77:   decode_seg = {1'b1, 4'hA};
            7'h1F:   decode_seg = {1'b1, 4'hB};
            7'h4E:   decode_seg = {1'b1, 4'hC};
            7'h3D:   decode_seg = {1'b1, 4'hD};
            7'h4F:   decode_seg = {1'b1, 4'hE};
            7'h47:   decode_seg = {1'b1, 4'hF};
            default: decode_seg = 5'b0;
        endcase
    endfunction

    logic [6:0]    a_q;
    logic [3:0]    an_q;
    logic [SW-1:0] stab_q, stab_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   value_q, value_d;
    logic          fv_q, fv_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic       changed;
    logic       capture;
    logic       timeout;
    logic [4:0] dec;
    logic [3:0] seen_new;

    // The live bus is compared with its registered copy, so a pair held from
    // edge t0 reaches STABLE_CYCLES-1 and captures exactly at edge t0+STABLE_CYCLES.
    assign changed  = {scan_io.an, scan_io.a_to_g} != {an_q, a_q};
    assign capture  = !changed && (stab_q == STAB_HIT) && (an_q != 4'b0000);
    assign timeout  = (state_q == ST_PARTIAL) && (timer_q == TIME_LAST);
    assign dec      = decode_seg(a_q);
    assign seen_new = seen_q | an_q;

    always_comb begin
        stab_d = stab_q;
        if (changed)
            stab_d = '0;
        else if (stab_q != STAB_MAX)
            stab_d = stab_q + SW'(1);
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = (state_q == ST_PARTIAL) ? timer_q + TW'(1) : timer_q;
        seen_d   = seen_q;
        shadow_d = shadow_q;
        value_d  = value_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;

        if (state_q == ST_DONE) begin
            value_d = shadow_q;
            fv_d    = 1'b1;
            seen_d  = 4'b0000;
            state_d = ST_EMPTY;
        end else if (capture && !$onehot(an_q)) begin
            err_d   = 1'b1;
            code_d  = ERR_ONEHOT;
            seen_d  = 4'b0000;
            timer_d = '0;
            state_d = ST_EMPTY;
        end else if (capture && !dec[4]) begin
            err_d   = 1'b1;
            code_d  = ERR_SEG;
            seen_d  = 4'b0000;
            timer_d = '0;
            state_d = ST_EMPTY;
        end else if (capture) begin
            for (int i = 0; i < 4; i++)
                if (an_q[i])
                    shadow_d[4*i +: 4] = dec[3:0];
            // A completing capture beats a coincident timeout.
            if (seen_new == 4'b1111) begin
                seen_d  = seen_new;
                state_d = ST_DONE;
            end else if (timeout) begin
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
                seen_d  = 4'b0000;
                timer_d = '0;
                state_d = ST_EMPTY;
            end else begin
                seen_d  = seen_new;
                state_d = ST_PARTIAL;
                if (state_q == ST_EMPTY)
                    timer_d = '0;
            end
        end else if (timeout) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            seen_d  = 4'b0000;
            timer_d = '0;
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_q      <= '0;
            an_q     <= '0;
            stab_q   <= '0;
            state_q  <= ST_EMPTY;
            timer_q  <= '0;
            seen_q   <= '0;
            shadow_q <= '0;
            value_q  <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            a_q      <= scan_io.a_to_g;
            an_q     <= scan_io.an;
            stab_q   <= stab_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            seen_q   <= seen_d;
            shadow_q <= shadow_d;
            value_q  <= value_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign scan_io.value       = value_q;
    assign scan_io.frame_valid = fv_q;
    assign scan_io.err         = err_q;
    assign scan_io.err_code    = code_q;
    assign scan_io.digit_seen  = seen_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scoreboard bench for seg7_scan_decoder: stimulus queues expected
// frame/error pulses (with their cycle), a negedge monitor pops and compares.
module tb_seg7_scan_decoder;
    localparam int K_FRAME = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int          kind;
        logic [15:0] data;
        int          cycle;
    } exp_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    int   dummy;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seg7_scan_if bus ();

    seg7_scan_decoder #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .scan_io(bus)
    );

    // Drives one scan word for 'hold' clock edges; optionally queues the pulse it
    // should cause 'delay' cycles after the drive point.
    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int hold,
                                 input int kind, input logic [15:0] data, input int delay,
                                 output int driveCyc);
        exp_t e;
        @(negedge clk);
        bus.an     = an;
        bus.a_to_g = seg;
        driveCyc   = cyc;
        if (kind != 0) begin
            e.kind  = kind;
            e.data  = data;
            e.cycle = cyc + delay;
            sbq.push_back(e);
        end
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (clr_n && (bus.frame_valid || bus.err)) begin
            exp_t        e;
            int          actKind;
            logic [15:0] actData;
            checks++;
            actKind = bus.frame_valid ? K_FRAME : K_ERR;
            actData = bus.frame_valid ? bus.value : {14'b0, bus.err_code};
            if (bus.frame_valid && bus.err) begin
                failures++;
                $display("[TB] FAIL pulse_overlap: frame_valid and err both high at cycle %0d", cyc);
            end else if (sbq.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse: kind %0d data %h at cycle %0d, expected none",
                         actKind, actData, cyc);
            end else begin
                e = sbq.pop_front();
                if (actKind != e.kind || actData !== e.data || cyc != e.cycle) begin
                    failures++;
                    $display("[TB] FAIL pulse_match: got kind %0d data %h cycle %0d, expected kind %0d data %h cycle %0d",
                             actKind, actData, cyc, e.kind, e.data, e.cycle);
                end
            end
        end
    end

    initial begin
        bus.an     = 4'b0000;
        bus.a_to_g = 7'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_value", bus.value, 16'h0000);
        checkOutput("reset_digit_seen", {12'b0, bus.digit_seen}, 16'h0000);
        checkOutput("reset_err_code", {14'b0, bus.err_code}, 16'h0000);
        checkOutput("reset_frame_valid", {15'b0, bus.frame_valid}, 16'h0000);
        checkOutput("reset_err", {15'b0, bus.err}, 16'h0000);
        clr_n = 1'b1;

        // Two full cyclic scans of 0x1234: one frame each, 1 cycle after digit 3 capture.
        repeat (2) begin
            applyStimulus(4'b0001, 7'h33, 8, 0, 16'h0, 0, dummy);
            applyStimulus(4'b0010, 7'h79, 8, 0, 16'h0, 0, dummy);
            applyStimulus(4'b0100, 7'h6D, 8, 0, 16'h0, 0, dummy);
            applyStimulus(4'b1000, 7'h30, 8, K_FRAME, 16'h1234, 6, dummy);
        end
        applyStimulus(4'b0000, 7'h00, 8, 0, 16'h0, 0, dummy);
        checkOutput("scan_value", bus.value, 16'h1234);
        checkOutput("scan_digit_seen", {12'b0, bus.digit_seen}, 16'h0000);

        // Too-short window never captures.
        applyStimulus(4'b0001, 7'h7E, 3, 0, 16'h0, 0, dummy);
        applyStimulus(4'b0000, 7'h00, 8, 0, 16'h0, 0, dummy);
        checkOutput("short_digit_seen", {12'b0, bus.digit_seen}, 16'h0000);

        // Non-one-hot select after a partial capture.
        applyStimulus(4'b0001, 7'h7E, 8, 0, 16'h0, 0, dummy);
        checkOutput("partial_digit_seen", {12'b0, bus.digit_seen}, 16'h0001);
        applyStimulus(4'b0011, 7'h30, 8, K_ERR, 16'h0001, 5, dummy);
        checkOutput("onehot_digit_seen", {12'b0, bus.digit_seen}, 16'h0000);
        checkOutput("onehot_value", bus.value, 16'h1234);
        checkOutput("onehot_err_code", {14'b0, bus.err_code}, 16'h0001);

        // Illegal segment pattern.
        applyStimulus(4'b0100, 7'h01, 8, K_ERR, 16'h0002, 5, dummy);
        checkOutput("segerr_err_code", {14'b0, bus.err_code}, 16'h0002);
        checkOutput("segerr_digit_seen", {12'b0, bus.digit_seen}, 16'h0000);

        // Incomplete frame times out 256 cycles after its first capture.
        applyStimulus(4'b0001, 7'h33, 8, K_ERR, 16'h0003, 5 + 256, dummy);
        applyStimulus(4'b0010, 7'h79, 8, 0, 16'h0, 0, dummy);
        applyStimulus(4'b0100, 7'h6D, 8, 0, 16'h0, 0, dummy);
        checkOutput("timeout_pre_digit_seen", {12'b0, bus.digit_seen}, 16'h0007);
        applyStimulus(4'b0000, 7'h00, 300, 0, 16'h0, 0, dummy);
        checkOutput("timeout_digit_seen", {12'b0, bus.digit_seen}, 16'h0000);
        checkOutput("timeout_value", bus.value, 16'h1234);
        checkOutput("timeout_err_code", {14'b0, bus.err_code}, 16'h0003);

        // Re-capturing digit 0 overwrites it silently.
        applyStimulus(4'b0001, 7'h47, 8, 0, 16'h0, 0, dummy);
        applyStimulus(4'b0001, 7'h77, 8, 0, 16'h0, 0, dummy);
        applyStimulus(4'b0010, 7'h7E, 8, 0, 16'h0, 0, dummy);
        applyStimulus(4'b0100, 7'h7E, 8, 0, 16'h0, 0, dummy);
        applyStimulus(4'b1000, 7'h7E, 8, K_FRAME, 16'h000A, 6, dummy);
        applyStimulus(4'b0000, 7'h00, 8, 0, 16'h0, 0, dummy);
        checkOutput("overwrite_value", bus.value, 16'h000A);

        // Asynchronous reset in the middle of a frame.
        applyStimulus(4'b0001, 7'h7E, 8, 0, 16'h0, 0, dummy);
        applyStimulus(4'b0010, 7'h7E, 8, 0, 16'h0, 0, dummy);
        checkOutput("midreset_pre_digit_seen", {12'b0, bus.digit_seen}, 16'h0003);
        #2;
        clr_n = 1'b0;
        bus.an     = 4'b0000;
        bus.a_to_g = 7'h00;
        #1;
        checkOutput("midreset_value", bus.value, 16'h0000);
        checkOutput("midreset_digit_seen", {12'b0, bus.digit_seen}, 16'h0000);
        checkOutput("midreset_err_code", {14'b0, bus.err_code}, 16'h0000);
        @(negedge clk);
        clr_n = 1'b1;
        applyStimulus(4'b0000, 7'h00, 20, 0, 16'h0, 0, dummy);
        checkOutput("postreset_digit_seen", {12'b0, bus.digit_seen}, 16'h0000);

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_pulses: %0d expected pulses never seen, expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 4-digit seven-segment driver: monitors the a_to_g/an scan bus and reconstructs the 16-bit hex value being displayed.
- Filters scan transitions with a stability window, decodes segment patterns back to nibbles, and assembles a frame once all four digits are captured.
- Flags protocol errors. Used as an on-chip checker and as a bench monitor for display logic.

Parameters:
- STABLE_CYCLES, 4: consecutive registered cycles the (an, a_to_g) pair must hold before it is captured; legal range is 2 or more.
- TIMEOUT_CYCLES, 256: maximum cycles from the first capture of a frame to frame completion.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- a_to_g  input  7  segment bus; bit6=a … bit0=g; active-high.
- an  input  4  digit select; active-high, one-hot; an[i] selects nibble i (bits 4i+3:4i).
- value  output  16  last complete decoded frame.
- frame_valid  output  1  one-cycle pulse when value updates.
- err  output  1  one-cycle pulse on protocol error.
- err_code  output  2  cause of the most recent error; holds until the next error or reset.
- digit_seen  output  4  digits captured in the current partial frame.

Behaviour:
- Reset (clr_n=0, async): value=0, frame_valid=0, err=0, err_code=0, digit_seen=0, shadow nibbles=0, stability counter=0, frame timer=0, input registers=0.
  - Reset mid-frame discards the partial frame; no pulses are emitted.
- Input stage:
  - a_to_g and an are registered every clk into a_q/an_q.
  - stab_cnt is cleared when {an_q,a_to_g_q} differs from its value on the previous cycle. Otherwise it increments, saturating at STABLE_CYCLES.
- Capture event:
  - Fires on the single edge where stab_cnt == STABLE_CYCLES-1 and the pair is unchanged.
  - For an input held constant from edge t0 onward, capture occurs at edge t0+STABLE_CYCLES.
  - At most one capture per stable window; a new capture requires a change.
- Capture handling, in priority order:
  - an_q==0000: blank period; ignored, no error.
  - an_q not one-hot: err pulse next edge, err_code=01, digit_seen cleared, frame timer cleared.
  - a_to_g_q not in the decode table: err pulse, err_code=10, digit_seen cleared, frame timer cleared.
  - Otherwise: shadow[i] gets the decoded nibble and digit_seen[i] is set.
  - Capturing an already-seen digit overwrites its nibble with no error.
- Decode table (hex nibble → a_to_g):
  - 0→7E, 1→30, 2→6D, 3→79, 4→33, 5→5B, 6→5F, 7→70
  - 8→7F, 9→7B, A→77, B→1F, C→4E, D→3D, E→4F, F→47
- Frame FSM states:
  - EMPTY (digit_seen==0)
  - PARTIAL
  - DONE (transient, one cycle)
- EMPTY → PARTIAL: on first valid capture; frame timer starts at 0.
- PARTIAL → DONE: when a capture makes digit_seen all ones.
- DONE, at the next edge:
  - value gets the shadow nibbles, including the just-written nibble.
  - frame_valid=1 for one cycle.
  - digit_seen cleared; state → EMPTY.
  - Latency from the completing capture edge to value/frame_valid: 1 cycle.
- PARTIAL timeout:
  - The timer increments every cycle; at TIMEOUT_CYCLES-1 without completion the FSM goes to EMPTY.
  - err pulse with err_code=11; digit_seen cleared.
  - Valid captures do not restart the timer.
- Simultaneous events:
  - An error capture in the same cycle as a timeout reports the capture error code.
  - A completing capture on the timeout cycle wins: frame_valid fires, no err.
- frame_valid and err are never asserted in the same cycle.
- value is never altered by errors or partial frames.

Test Plan:
- Scan 0x1234 cyclically, each digit held 8 cycles, (an,seg) = (0001,33),(0010,79),(0100,6D),(1000,30) -> frame_valid pulses exactly once per scan, 1 cycle after the an=1000 capture; value=0x1234; err never asserts.
- an=0001, seg=7E held only 3 cycles, then an=0000 -> no capture; digit_seen stays 0000.
- an=0011, seg=30 held 8 cycles -> one err pulse; err_code=01; digit_seen=0000; value unchanged.
- an=0100, seg=0000001 held 8 cycles -> err pulse; err_code=10.
- Capture digits 0, 1, 2 only, then hold an=0000 -> err pulse with err_code=11 exactly TIMEOUT_CYCLES (256) cycles after the first capture; digit_seen cleared.
- Capture digit0=F (47), then digit0=A (77), then digits 1–3 = 0 (7E) -> value=0x000A. A separate run drops clr_n after two captures -> all outputs return to 0 asynchronously and no frame_valid follows.
